// File: rtl/video_timing_pkg.sv
// Shared types for the raster timing generator.
// One timing_t describes one axis (h or v) of one video mode.
package video_timing_pkg;

   localparam int CE_DIV_W = 4;

   typedef struct packed {
      int unsigned act;
      int unsigned fp;
      int unsigned sync;
      int unsigned bp;
   } timing_t;

   function automatic int unsigned tot(timing_t t);
      return t.act + t.fp + t.sync + t.bp;
   endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// Control and raster outputs of the video timing generator.
// The master side is the generator, the slave side the video sink.
interface video_timing_gen_if #(
   parameter int unsigned CNT_W = 12
);

   logic             enable;
   logic             mode_sel;
   logic             ce_pix;
   logic [CNT_W-1:0] hcount;
   logic [CNT_W-1:0] vcount;
   logic             de;
   logic             hblank;
   logic             vblank;
   logic             hs;
   logic             vs;
   logic             frame_start;
   logic             mode_act;

   modport master (
      input  enable, mode_sel,
      output ce_pix, hcount, vcount, de,
      output hblank, vblank, hs, vs,
      output frame_start, mode_act
   );

   modport slave (
      output enable, mode_sel,
      input  ce_pix, hcount, vcount, de,
      input  hblank, vblank, hs, vs,
      input  frame_start, mode_act
   );

endinterface

// File: rtl/video_ce_div.sv
// Pixel clock-enable divider: one ce pulse every div clocks.
// clr restarts the count so the first pulse comes div clocks later.
module video_ce_div
   import video_timing_pkg::*;
(
   input  logic                clk_vid,
   input  logic                reset_n,
   input  logic                clr,
   input  logic [CE_DIV_W-1:0] div,
   output logic                ce
);

   logic [CE_DIV_W-1:0] cnt;

   always_ff @(posedge clk_vid or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
         ce  <= 1'b0;
      end else if (clr) begin
         cnt <= '0;
         ce  <= 1'b0;
      end else if (cnt >= div - CE_DIV_W'(1)) begin
         cnt <= '0;
         ce  <= 1'b1;
      end else begin
         cnt <= cnt + CE_DIV_W'(1);
         ce  <= 1'b0;
      end
   end

endmodule

// File: rtl/video_timing_gen.sv
// Two-mode raster timing generator: sync, blank, de and coordinates.
// Mode changes take effect only at the end of a complete frame.
module video_timing_gen
   import video_timing_pkg::*;
#(
   parameter int unsigned CNT_W    = 12,
   parameter int unsigned H_ACT_0  = 640,
   parameter int unsigned H_FP_0   = 16,
   parameter int unsigned H_SYNC_0 = 96,
   parameter int unsigned H_BP_0   = 48,
   parameter int unsigned V_ACT_0  = 480,
   parameter int unsigned V_FP_0   = 10,
   parameter int unsigned V_SYNC_0 = 2,
   parameter int unsigned V_BP_0   = 33,
   parameter int unsigned CE_DIV_0 = 1,
   parameter int unsigned H_ACT_1  = 320,
   parameter int unsigned H_FP_1   = 8,
   parameter int unsigned H_SYNC_1 = 48,
   parameter int unsigned H_BP_1   = 24,
   parameter int unsigned V_ACT_1  = 200,
   parameter int unsigned V_FP_1   = 12,
   parameter int unsigned V_SYNC_1 = 2,
   parameter int unsigned V_BP_1   = 48,
   parameter int unsigned CE_DIV_1 = 2,
   parameter bit          HS_POL   = 1'b0,
   parameter bit          VS_POL   = 1'b0
) (
   input logic                clk_vid,
   input logic                reset_n,
   video_timing_gen_if.master bus
);

   localparam timing_t H0 = '{act: H_ACT_0, fp: H_FP_0,
                              sync: H_SYNC_0, bp: H_BP_0};
   localparam timing_t V0 = '{act: V_ACT_0, fp: V_FP_0,
                              sync: V_SYNC_0, bp: V_BP_0};
   localparam timing_t H1 = '{act: H_ACT_1, fp: H_FP_1,
                              sync: H_SYNC_1, bp: H_BP_1};
   localparam timing_t V1 = '{act: V_ACT_1, fp: V_FP_1,
                              sync: V_SYNC_1, bp: V_BP_1};
   localparam longint unsigned MAX_TOT = 64'd1 << CNT_W;

   if (longint'(tot(H0)) > MAX_TOT || longint'(tot(V0)) > MAX_TOT ||
       longint'(tot(H1)) > MAX_TOT || longint'(tot(V1)) > MAX_TOT)
   begin : g_geom_err
      $error("video_timing_gen: line/frame total exceeds CNT_W range");
   end

   if (CE_DIV_0 == 0 || CE_DIV_0 > 15 ||
       CE_DIV_1 == 0 || CE_DIV_1 > 15)
   begin : g_div_err
      $error("video_timing_gen: CE_DIV must be 1..15");
   end

   logic [CNT_W-1:0]    h, v;
   logic                mode_q;
   timing_t             th, tv;
   logic [CE_DIV_W-1:0] div;
   logic [31:0]         h32, v32;
   logic                ce, clr, mode_chg;
   logic                h_last, v_last;
   logic                h_act, v_act, h_sync, v_sync;

   logic [CNT_W-1:0] hcount_q, vcount_q;
   logic             de_q, hblank_q, vblank_q;
   logic             hs_q, vs_q, fs_q;

   always_comb begin
      th  = mode_q ? H1 : H0;
      tv  = mode_q ? V1 : V0;
      div = mode_q ? CE_DIV_W'(CE_DIV_1)
                   : CE_DIV_W'(CE_DIV_0);
      h32 = 32'(h);
      v32 = 32'(v);
      h_last = h32 == tot(th) - 1;
      v_last = v32 == tot(tv) - 1;
      h_act  = h32 < th.act;
      v_act  = v32 < tv.act;
      h_sync = h32 >= th.act + th.fp &&
               h32 < th.act + th.fp + th.sync;
      v_sync = v32 >= tv.act + tv.fp &&
               v32 < tv.act + tv.fp + tv.sync;
      // restart the divider so the new mode's first pixel gets a full period
      mode_chg = ce && h_last && v_last &&
                 (bus.mode_sel != mode_q);
      clr = !bus.enable || mode_chg;
   end

   video_ce_div u_ce_div (
      .clk_vid (clk_vid),
      .reset_n (reset_n),
      .clr     (clr),
      .div     (div),
      .ce      (ce)
   );

   always_ff @(posedge clk_vid or negedge reset_n) begin
      if (!reset_n) begin
         h        <= '0;
         v        <= '0;
         mode_q   <= 1'b0;
         hcount_q <= '0;
         vcount_q <= '0;
         de_q     <= 1'b0;
         hblank_q <= 1'b1;
         vblank_q <= 1'b1;
         hs_q     <= ~HS_POL;
         vs_q     <= ~VS_POL;
         fs_q     <= 1'b0;
      end else if (!bus.enable) begin
         h        <= '0;
         v        <= '0;
         hcount_q <= '0;
         vcount_q <= '0;
         de_q     <= 1'b0;
         hblank_q <= 1'b1;
         vblank_q <= 1'b1;
         hs_q     <= ~HS_POL;
         vs_q     <= ~VS_POL;
         fs_q     <= 1'b0;
      end else begin
         fs_q <= ce && h == '0 && v == '0;
         if (ce) begin
            hcount_q <= h;
            vcount_q <= v;
            de_q     <= h_act && v_act;
            hblank_q <= !h_act;
            vblank_q <= !v_act;
            hs_q     <= h_sync ? HS_POL : ~HS_POL;
            vs_q     <= v_sync ? VS_POL : ~VS_POL;
            if (h_last) begin
               h <= '0;
               if (v_last) begin
                  v      <= '0;
                  mode_q <= bus.mode_sel;
               end else begin
                  v <= v + CNT_W'(1);
               end
            end else begin
               h <= h + CNT_W'(1);
            end
         end
      end
   end

   assign bus.ce_pix      = ce;
   assign bus.hcount      = hcount_q;
   assign bus.vcount      = vcount_q;
   assign bus.de          = de_q;
   assign bus.hblank      = hblank_q;
   assign bus.vblank      = vblank_q;
   assign bus.hs          = hs_q;
   assign bus.vs          = vs_q;
   assign bus.frame_start = fs_q;
   assign bus.mode_act    = mode_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Randomized bench for video_timing_gen against a pixel-index model.
// Small geometry: H 8/2/2/4, V 4/1/1/2, dividers 1 and 3.
module tb_video_timing_gen;

   localparam int HA = 8, HF = 2, HSY = 2, HB = 4;
   localparam int VA = 4, VF = 1, VSY = 1, VB = 2;
   localparam int HT = HA + HF + HSY + HB;
   localparam int VT = VA + VF + VSY + VB;
   localparam int FR = HT * VT;
   localparam int D0 = 1, D1 = 3;

   logic clk = 1'b0;
   logic reset_n;

   video_timing_gen_if #(.CNT_W(12)) vif ();

   video_timing_gen #(
      .CNT_W(12),
      .H_ACT_0(HA), .H_FP_0(HF), .H_SYNC_0(HSY), .H_BP_0(HB),
      .V_ACT_0(VA), .V_FP_0(VF), .V_SYNC_0(VSY), .V_BP_0(VB),
      .CE_DIV_0(D0),
      .H_ACT_1(HA), .H_FP_1(HF), .H_SYNC_1(HSY), .H_BP_1(HB),
      .V_ACT_1(VA), .V_FP_1(VF), .V_SYNC_1(VSY), .V_BP_1(VB),
      .CE_DIV_1(D1),
      .HS_POL(1'b0), .VS_POL(1'b0)
   ) dut (
      .clk_vid (clk),
      .reset_n (reset_n),
      .bus     (vif)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   always @(posedge clk) cyc++;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at cyc %0d",
                  tag, got, exp, cyc);
      end
   endtask

   // Model: m_pix is the linear index of the next pixel to emit,
   // m_since counts enabled clocks since the divider last restarted.
   int m_pix, m_since;
   bit m_ce, m_mode;
   int e_h, e_v;
   bit e_de, e_hb, e_vb, e_hs, e_vs, e_fs;

   function automatic int div_of(bit m);
      return m ? D1 : D0;
   endfunction

   task automatic model_clear();
      m_pix = 0; m_since = 0; m_ce = 0;
      e_h = 0; e_v = 0; e_de = 0; e_hb = 1; e_vb = 1;
      e_hs = 1; e_vs = 1; e_fs = 0;
   endtask

   always @(posedge clk or negedge reset_n) begin : model
      bit ce_old;
      int p;
      if (!reset_n) begin
         m_mode = 0;
         model_clear();
      end else if (!vif.enable) begin
         model_clear();
      end else begin
         ce_old = m_ce;
         p      = m_pix;
         e_fs   = ce_old && p == 0;
         if (ce_old) begin
            e_h  = p % HT;
            e_v  = p / HT;
            e_hb = e_h >= HA;
            e_vb = e_v >= VA;
            e_de = !e_hb && !e_vb;
            e_hs = !(e_h >= HA + HF && e_h < HA + HF + HSY);
            e_vs = !(e_v >= VA + VF && e_v < VA + VF + VSY);
            m_pix = (p + 1) % FR;
         end
         if (ce_old && p == FR - 1 && vif.mode_sel != m_mode) begin
            m_mode  = vif.mode_sel;
            m_since = 0;
            m_ce    = 0;
         end else begin
            m_since++;
            m_ce = (m_since % div_of(m_mode)) == 0;
         end
      end
   end

   bit chk_en = 0;
   bit track  = 0;
   int hmax, vmax;

   always @(negedge clk) begin
      if (chk_en) begin
         chk("ce_pix", vif.ce_pix, m_ce);
         chk("hcount", vif.hcount, e_h);
         chk("vcount", vif.vcount, e_v);
         chk("de", vif.de, e_de);
         chk("hblank", vif.hblank, e_hb);
         chk("vblank", vif.vblank, e_vb);
         chk("hs", vif.hs, e_hs);
         chk("vs", vif.vs, e_vs);
         chk("frame_start", vif.frame_start, e_fs);
         chk("mode_act", vif.mode_act, m_mode);
      end
      if (track) begin
         if (int'(vif.hcount) > hmax) hmax = int'(vif.hcount);
         if (int'(vif.vcount) > vmax) vmax = int'(vif.vcount);
      end
   end

   task automatic wait_fs(output int t);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (vif.frame_start !== 1'b1 && n < 2000);
      chk("fs_wait", vif.frame_start, 1);
      t = cyc;
   endtask

   task automatic wait_hv(input int h, input int v);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(vif.hcount == h && vif.vcount == v) && n < 2000);
      chk("hv_wait", vif.hcount == h && vif.vcount == v, 1);
   endtask

   task automatic wait_hs_low();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (vif.hs !== 1'b0 && n < 2000);
      chk("hs_wait", vif.hs, 0);
   endtask

   initial begin
      int t0, t1, ten;
      reset_n      = 1'b0;
      vif.enable   = 1'b0;
      vif.mode_sel = 1'b0;
      repeat (3) @(negedge clk);
      chk_en = 1;
      chk("rst_hblank", vif.hblank, 1);
      chk("rst_hs", vif.hs, 1);
      #2 reset_n = 1'b1;
      @(negedge clk);
      vif.enable = 1'b1;

      // mode 0 frame rate
      wait_fs(t0);
      wait_fs(t1);
      chk("period_m0", t1 - t0, FR * D0);

      // wrap over three frames
      hmax = 0; vmax = 0; track = 1;
      repeat (3) wait_fs(t0);
      track = 0;
      chk("hmax", hmax, HT - 1);
      chk("vmax", vmax, VT - 1);

      // mode request mid-frame
      wait_hv(3, 2);
      vif.mode_sel = 1'b1;
      @(negedge clk);
      chk("mode_hold", vif.mode_act, 0);
      wait_fs(t0);
      chk("mode_new", vif.mode_act, 1);
      wait_fs(t1);
      chk("period_m1", t1 - t0, FR * D1);

      // enable drop and restart
      wait_hv(5, 1);
      vif.enable = 1'b0;
      @(negedge clk);
      chk("dis_h", vif.hcount, 0);
      chk("dis_de", vif.de, 0);
      chk("dis_hs", vif.hs, 1);
      chk("dis_vs", vif.vs, 1);
      repeat ($urandom_range(1, 8)) @(negedge clk);
      vif.enable = 1'b1;
      ten = cyc;
      wait_fs(t0);
      chk("reen_lat", t0 - ten, D1 + 1);
      chk("reen_h", vif.hcount, 0);
      chk("reen_v", vif.vcount, 0);

      // asynchronous reset in the middle of hsync
      wait_hs_low();
      #2 reset_n = 1'b0;
      #1;
      chk("arst_hs", vif.hs, 1);
      chk("arst_mode", vif.mode_act, 0);
      @(negedge clk);
      #2 reset_n = 1'b1;
      wait_fs(t0);
      chk("rst_restart_h", vif.hcount, 0);
      chk("rst_restart_v", vif.vcount, 0);

      // random enable and mode traffic
      repeat (3000) begin
         @(negedge clk);
         if ($urandom_range(0, 199) == 0) vif.enable = !vif.enable;
         if ($urandom_range(0, 59) == 0) vif.mode_sel = !vif.mode_sel;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
